johnson_seq_ctrl: RTL and testbench
===================================

Name: johnson_seq_ctrl

Overview:
- Command-driven sequencer that owns a 4-bit Johnson counter and steps it a requested number of times in a requested direction.
- Supports pause, abort, one-hot phase decode and illegal-code detection with recovery.
- Sits between the control FSMs, which issue valid/ready commands, and the logic consuming the 2*WIDTH-phase timing.

Parameters:
- WIDTH, 4, Johnson register width; sequence length is 2*WIDTH states.
- CNT_W, 8, width of the step-count field.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_dir  in  1  1 = up {q[W-2:0], ~q[W-1]}; 0 = down {~q[0], q[W-1:1]}.
- cmd_steps  in  CNT_W  number of shifts to perform.
- abort  in  1  stop the active command.
- pause  in  1  hold the counter without ending the command.
- q_out  out  WIDTH  Johnson register.
- phase  out  2*WIDTH  one-hot phase index of q_out.
- busy  out  1  state is RUN or PAUSED.
- done  out  1  one-cycle pulse when a command completes normally.
- aborted  out  1  one-cycle pulse when a command ends by abort or illegal-code recovery.
- err  out  1  sticky flag: illegal code detected.

Behaviour:
- Clock and reset: one clock (clk); reset (clear) is asynchronous and active-high.
- Reset values: q_out=0, phase=0000_0001, FSM=IDLE, cmd_ready=1, busy=0, done=0, aborted=0, err=0, remaining=0, dir=0.
- FSM states: IDLE, RUN, PAUSED.
- IDLE:
  - Handshake occurs on the edge where cmd_valid&cmd_ready.
  - On handshake, latch dir and remaining=cmd_steps.
  - steps!=0 -> RUN.
  - steps==0 -> stay IDLE, done=1 for the next cycle, q_out unchanged, err cleared.
  - err clears on any accepted command.
- RUN:
  - Each edge: shift one position in the latched direction and decrement remaining.
  - On the edge that performs the shift with remaining==1: go to IDLE and set done=1 for one cycle.
  - Latency: command accepted at edge N; shifts at edges N+1..N+steps; done is high during the cycle after edge N+steps, coincident with the final q_out.
  - A new command may be accepted in that done cycle (back-to-back).
- pause:
  - pause=1 in RUN -> PAUSED, with no shift on that edge.
  - PAUSED holds q_out and remaining; returns to RUN on the first edge with pause=0 (no shift on that edge); shifting resumes the following edge.
  - pause is ignored in IDLE.
- abort:
  - In RUN or PAUSED: no shift on that edge, go to IDLE, aborted=1 for one cycle, q_out holds.
  - Ignored in IDLE.
- Priority per edge: clear > illegal-code recovery > abort > pause > step.
- Commands are never accepted while busy (cmd_ready=0); cmd_valid may stay high and is accepted on return to IDLE.
- Legal codes are the 2*WIDTH Johnson codes only: thermometer 0..01..1 or 1..10..0.
- Illegal-code recovery (any state, checked every cycle):
  - Next edge: q_out=0, err=1, FSM=IDLE.
  - aborted=1 if the FSM was busy.
- Phase decode (combinational from q_out; up-direction order), bit k set for:
  - 0000->0, 0001->1, 0011->2, 0111->3
  - 1111->4, 1110->5, 1100->6, 1000->7
  - Generalised for WIDTH.
  - Illegal code -> phase=0.
- Wrap-around is natural: 8 up-shifts return to the start code; down traverses phases in descending index order.
- q_out persists across commands; only clear or recovery zeroes it.
- clear mid-command: immediate return to reset values; no done or aborted pulse.

Decomposition:
- Package johnson_pkg:
  - FSM state enum {IDLE, RUN, PAUSED}.
  - Direction constants DIR_UP=1, DIR_DOWN=0.
  - Function is_legal_johnson(q).
  - Function johnson_phase(q) returning one-hot.
- Sub-module johnson_core:
  - Ports: clk, clear, en, dir, sync_zero, q.
  - Registered shift; sync_zero overrides en.
  - The controller FSM, step counter and pulses live in johnson_seq_ctrl.

Test Plan:
- Reset, then cmd up steps=3 from 0000 -> q 0001, 0011, 0111 on successive edges; done one cycle with q=0111, phase=0000_1000; busy low after.
- cmd down steps=2 from 0000 -> q 1000, 1100; phase 1000_0000 then 0100_0000; done once.
- cmd up steps=9 from 0000 -> full wrap, final q=0001; back-to-back second cmd steps=1 accepted in the done cycle -> q=0011 the next edge.
- steps=4 up, pause asserted for 3 cycles after the 2nd shift -> q holds 0011 for 4 cycles (3 paused plus the resume edge), then 0111, 1111; done only after the 4th shift.
- steps=10 up, abort after the 3rd shift -> q holds 0111, aborted pulses once, no done, cmd_ready=1 next cycle; steps=0 cmd -> done pulse, q unchanged.
- Force q_out=0101 during RUN -> next edge q=0000, err=1, aborted=1, IDLE; next accepted cmd clears err; also clear asserted mid-RUN -> immediate reset values, no pulses.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson sequencer.
//   state_e            : controller FSM states
//   DIR_UP / DIR_DOWN  : shift direction encodings
//   is_legal_johnson() : true for the 2*w valid Johnson codes of width w
//   johnson_phase()    : one-hot phase index (up-direction order), 0 if illegal
// Helpers take a zero-extended code of up to JMAX_W bits plus the live width.
package johnson_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned JMAX_W = 16;

  // Legal codes are thermometers 0..01..1, or their complements 1..10..0.
  // A value v is a low-aligned thermometer exactly when (v+1) & v == 0.
  function automatic logic is_legal_johnson(input logic [JMAX_W-1:0] q,
                                            input int unsigned       w);
    logic [JMAX_W-1:0] mask;
    logic [JMAX_W-1:0] v;
    logic [JMAX_W-1:0] nv;
    mask = '0;
    for (int unsigned i = 0; i < JMAX_W; i++) begin
      if (i < w) mask[i] = 1'b1;
    end
    v  = q & mask;
    nv = ~q & mask;
    return (((v + JMAX_W'(1)) & v) == '0) || (((nv + JMAX_W'(1)) & nv) == '0);
  endfunction

  // Filling phase (msb clear): index = number of ones.
  // Draining phase (msb set):  index = 2w - number of ones.
  function automatic logic [2*JMAX_W-1:0] johnson_phase(input logic [JMAX_W-1:0] q,
                                                        input int unsigned       w);
    logic [2*JMAX_W-1:0] ph;
    int unsigned ones;
    int unsigned idx;
    ph   = '0;
    ones = 0;
    for (int unsigned i = 0; i < JMAX_W; i++) begin
      if ((i < w) && q[i]) ones++;
    end
    if (is_legal_johnson(q, w)) begin
      idx     = q[w-1] ? (2 * w - ones) : ones;
      ph[idx] = 1'b1;
    end
    return ph;
  endfunction

endpackage

// File: rtl/johnson_seq_ctrl_core.sv
// Johnson shift register.
//   clk, clear : clock, asynchronous active-high reset (register -> 0)
//   en         : perform one shift this edge
//   dir        : DIR_UP {q[W-2:0], ~q[W-1]}, DIR_DOWN {~q[0], q[W-1:1]}
//   sync_zero  : synchronous zero, overrides en
//   q          : current register value
module johnson_core
  import johnson_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             dir,
  input  logic             sync_zero,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (sync_zero) begin
      q_d = '0;
    end else if (en) begin
      case (dir)
        DIR_UP:   q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        DIR_DOWN: q_d = {~q_q[0], q_q[WIDTH-1:1]};
        default:  q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Command-driven sequencer stepping a Johnson counter.
//   clk, clear          : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_dir, cmd_steps  : direction and number of shifts
//   abort, pause        : stop / hold the active command
//   q_out, phase        : Johnson register and its one-hot phase
//   busy                : RUN or PAUSED
//   done, aborted       : one-cycle completion pulses
//   err                 : sticky illegal-code flag, cleared by an accepted command
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [CNT_W-1:0]   cmd_steps,
  input  logic               abort,
  input  logic               pause,
  output logic [WIDTH-1:0]   q_out,
  output logic [2*WIDTH-1:0] phase,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] q_cur;
  logic             legal;
  logic             shift_en;
  logic             sync_zero;

  johnson_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .clear    (clear),
    .en       (shift_en),
    .dir      (dir_q),
    .sync_zero(sync_zero),
    .q        (q_cur)
  );

  assign legal = is_legal_johnson(JMAX_W'(q_cur), WIDTH);
  assign phase = (2*WIDTH)'(johnson_phase(JMAX_W'(q_cur), WIDTH));
  assign q_out = q_cur;

  // Recovery outranks acceptance, so ready drops while the code is illegal
  // rather than handshaking a command that would be discarded.
  assign cmd_ready = (state_q == IDLE) && legal;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign err       = err_q;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = err_q;
    shift_en  = 1'b0;
    sync_zero = 1'b0;

    if (!legal) begin
      sync_zero = 1'b1;
      err_d     = 1'b1;
      state_d   = IDLE;
      rem_d     = '0;
      aborted_d = (state_q != IDLE);
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            dir_d = cmd_dir;
            rem_d = cmd_steps;
            err_d = 1'b0;
            if (cmd_steps == '0) done_d  = 1'b1;
            else                 state_d = RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
          end else if (pause) begin
            state_d = PAUSED;
          end else begin
            shift_en = 1'b1;
            rem_d    = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (abort) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
          end else if (!pause) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl with hand-computed expected values.
module tb_johnson_seq_ctrl;
  import johnson_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;

  logic            clk = 1'b0;
  logic            clear;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_dir;
  logic [CW-1:0]   cmd_steps;
  logic            abort;
  logic            pause;
  logic [W-1:0]    q_out;
  logic [2*W-1:0]  phase;
  logic            busy;
  logic            done;
  logic            aborted;
  logic            err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  johnson_seq_ctrl #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_steps(cmd_steps),
    .abort    (abort),
    .pause    (pause),
    .q_out    (q_out),
    .phase    (phase),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // q / done / busy in one call; each is still its own comparison.
  task automatic chk_st(input string tag, input logic [W-1:0] eq, input logic ed, input logic eb);
    chk({tag, "_q"},    32'(q_out), 32'(eq));
    chk({tag, "_done"}, 32'(done),  32'(ed));
    chk({tag, "_busy"}, 32'(busy),  32'(eb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic d, input logic [CW-1:0] s);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_steps = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
    abort = 1'b0; pause = 1'b0;
    #1;
    do_reset();

    // Reset state
    chk("rst_q",       32'(q_out),     32'h0);
    chk("rst_phase",   32'(phase),     32'h01);
    chk("rst_ready",   32'(cmd_ready), 32'h1);
    chk("rst_busy",    32'(busy),      32'h0);
    chk("rst_done",    32'(done),      32'h0);
    chk("rst_aborted", 32'(aborted),   32'h0);
    chk("rst_err",     32'(err),       32'h0);

    // Up 3 from 0000
    issue(DIR_UP, 8'd3);
    chk_st("up3_acc", 4'b0000, 1'b0, 1'b1);
    chk("up3_ready", 32'(cmd_ready), 32'h0);
    tick(); chk_st("up3_s1", 4'b0001, 1'b0, 1'b1);
    tick(); chk_st("up3_s2", 4'b0011, 1'b0, 1'b1);
    tick(); chk_st("up3_s3", 4'b0111, 1'b1, 1'b0);
    chk("up3_phase", 32'(phase), 32'h08);
    tick(); chk_st("up3_after", 4'b0111, 1'b0, 1'b0);

    // Down 2 from 0000
    do_reset();
    issue(DIR_DOWN, 8'd2);
    tick(); chk_st("dn2_s1", 4'b1000, 1'b0, 1'b1);
    chk("dn2_ph1", 32'(phase), 32'h80);
    tick(); chk_st("dn2_s2", 4'b1100, 1'b1, 1'b0);
    chk("dn2_ph2", 32'(phase), 32'h40);
    tick(); chk("dn2_done_once", 32'(done), 32'h0);

    // Up 9: full wrap, then back-to-back single step
    do_reset();
    issue(DIR_UP, 8'd9);
    for (int i = 0; i < 8; i++) tick();
    chk_st("wrap_s8", 4'b0000, 1'b0, 1'b1);
    tick(); chk_st("wrap_s9", 4'b0001, 1'b1, 1'b0);
    issue(DIR_UP, 8'd1);
    chk_st("b2b_acc", 4'b0001, 1'b0, 1'b1);
    tick(); chk_st("b2b_s1", 4'b0011, 1'b1, 1'b0);

    // Up 4 with a 3-cycle pause after the 2nd shift
    do_reset();
    issue(DIR_UP, 8'd4);
    tick(); tick();
    chk_st("pz_s2", 4'b0011, 1'b0, 1'b1);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_st("pz_hold", 4'b0011, 1'b0, 1'b1);
    end
    pause = 1'b0;
    tick(); chk_st("pz_resume", 4'b0011, 1'b0, 1'b1);
    tick(); chk_st("pz_s3", 4'b0111, 1'b0, 1'b1);
    tick(); chk_st("pz_s4", 4'b1111, 1'b1, 1'b0);
    chk("pz_phase", 32'(phase), 32'h10);

    // Up 10, abort after 3rd shift; then a zero-step command
    do_reset();
    issue(DIR_UP, 8'd10);
    tick(); tick(); tick();
    chk_st("ab_s3", 4'b0111, 1'b0, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_st("ab_edge", 4'b0111, 1'b0, 1'b0);
    chk("ab_pulse", 32'(aborted),   32'h1);
    chk("ab_ready", 32'(cmd_ready), 32'h1);
    tick();
    chk("ab_pulse_end", 32'(aborted), 32'h0);
    chk("ab_q_hold",    32'(q_out),   32'h7);
    issue(DIR_UP, 8'd0);
    chk_st("z0_acc", 4'b0111, 1'b1, 1'b0);
    tick(); chk_st("z0_after", 4'b0111, 1'b0, 1'b0);

    // Illegal code during RUN -> recovery
    do_reset();
    issue(DIR_UP, 8'd5);
    tick(); tick();
    chk_st("il_s2", 4'b0011, 1'b0, 1'b1);
    force dut.q_cur = 4'b0101;
    #1;
    chk("il_phase", 32'(phase), 32'h00);
    tick();
    release dut.q_cur;
    #1;
    chk_st("il_rec", 4'b0000, 1'b0, 1'b0);
    chk("il_err",     32'(err),     32'h1);
    chk("il_aborted", 32'(aborted), 32'h1);
    tick();
    chk("il_aborted_end", 32'(aborted), 32'h0);
    chk("il_err_sticky",  32'(err),     32'h1);
    issue(DIR_UP, 8'd1);
    chk("il_err_clr", 32'(err), 32'h0);
    tick(); chk_st("il_s1", 4'b0001, 1'b1, 1'b0);

    // Clear mid-RUN
    issue(DIR_UP, 8'd5);
    tick(); tick();
    chk_st("clr_s2", 4'b0111, 1'b0, 1'b1);
    clear = 1'b1;
    #1;
    chk_st("clr_async", 4'b0000, 1'b0, 1'b0);
    chk("clr_phase",   32'(phase),     32'h01);
    chk("clr_ready",   32'(cmd_ready), 32'h1);
    chk("clr_aborted", 32'(aborted),   32'h0);
    tick();
    clear = 1'b0;
    tick();
    chk_st("clr_after", 4'b0000, 1'b0, 1'b0);
    chk("clr_after_ab", 32'(aborted), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
